clic_unwind: RTL
================

CLIC_UNWIND -- requirements
Module: clic_unwind

Interface
REQ-001 Parameter Depth, default config_pkg::ClicStackDepth (8): number of nesting entries.
REQ-002 Parameter PrioW, default config_pkg::ClicPrioWidth (3): width of a saved threshold.
REQ-003 Parameter PcW, default config_pkg::IMemAddrWidth: width of a saved return pc.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 push  in  1  interrupt entry taken this cycle (from n_clic).
REQ-007 push_pc  in  PcW  return pc to save (interrupted pc_in).
REQ-008 push_prio  in  PrioW  threshold in force before entry (m_int_thresh value).
REQ-009 pop  in  1  interrupt return executed this cycle.
REQ-010 err_clr  in  1  clears sticky error flags.
REQ-011 tos_pc  out  PcW  top-of-stack return pc.
REQ-012 tos_prio  out  PrioW  top-of-stack saved threshold.
REQ-013 depth  out  $clog2(Depth+1)  current entry count.
REQ-014 empty / full  out  1 each  depth==0 / depth==Depth.
REQ-015 tail_chain  out  1  registered one-cycle pulse: push and pop coincided in the previous cycle.
REQ-016 overflow / underflow  out  1 each  sticky error flags.

Function
REQ-017 tos_pc/tos_prio SHALL be combinational from the entry at index depth-1, and SHALL be 0 when empty.
REQ-018 push && !pop && !full: write {push_pc, push_prio} at index depth; depth+1 next cycle.
REQ-019 pop && !push && !empty: depth-1 next cycle; the popped value SHALL be the tos seen in the pop cycle (zero-latency restore).
REQ-020 push && pop && !empty: the stack SHALL remain unchanged (tail-chain: return pc and prior threshold are kept); tail_chain SHALL be 1 in the next cycle.
REQ-021 push && pop && empty: treated as a push only; underflow SHALL NOT be set.
REQ-022 push && !pop && full: push ignored, depth unchanged, overflow set next cycle.
REQ-023 pop && !push && empty: pop ignored, depth stays 0, underflow set next cycle.
REQ-024 overflow/underflow SHALL stay set until err_clr or reset; err_clr together with a new error event SHALL leave the flag set (set wins).
REQ-025 Entries below the top SHALL never be modified by any operation except a push at their index.
REQ-026 depth SHALL never exceed Depth and never wrap below 0.
REQ-027 tail_chain SHALL be 0 in every cycle not directly following a qualifying push&&pop.

Reset
REQ-028 On reset: depth=0, empty=1, full=0, tail_chain=0, overflow=0, underflow=0, tos_pc=0, tos_prio=0; storage contents need not be cleared.
REQ-029 Reset SHALL take priority over push, pop and err_clr in the same cycle; a reset mid-nesting discards all entries.

Structure
REQ-030 ClicStackDepth and ClicPrioWidth SHALL be constants in config_pkg; a packed struct clic_frame_t {pc, prio} SHALL be a typedef in config_pkg.
REQ-031 Storage SHALL be an array of clic_frame_t inside clic_unwind with a single depth counter; no sub-module is required.

Verification
REQ-032 Reset, then push pc=10/prio=0, push pc=20/prio=1, push pc=30/prio=2 -> depth=3, tos=(30,2); three pops -> tos (20,1), (10,0), then empty with tos=0.
REQ-033 Depth=8: 8 pushes -> full=1; 9th push pc=99 -> depth stays 8, tos unchanged, overflow=1; err_clr -> overflow=0.
REQ-034 Pop on empty -> underflow=1, depth=0; push+pop on empty -> depth=1, underflow unchanged.
REQ-035 depth=2 tos=(20,1), push pc=40 + pop same cycle -> depth=2, tos=(20,1), tail_chain=1 for exactly one cycle.
REQ-036 Reset asserted together with push at depth=3 -> depth=0, empty=1, all flags 0 next cycle.
REQ-037 Random push/pop sequence against a reference model -> depth, tos and flags match every cycle.

Source files
------------

// File: rtl/config_pkg.sv
// Shared configuration constants and types for the interrupt nesting path.
// clic_frame_t is one saved context: return pc plus the threshold it displaced.
package config_pkg;

    localparam int ClicStackDepth = 8;
    localparam int ClicPrioWidth  = 3;
    localparam int IMemAddrWidth  = 16;

    typedef struct packed {
        logic [IMemAddrWidth-1:0] pc;
        logic [ClicPrioWidth-1:0] prio;
    } clic_frame_t;

endpackage

// File: rtl/clic_unwind.sv
// Nesting stack for CLIC interrupt entry/return: saves the interrupted pc and
// threshold on entry and exposes the frame to restore, with sticky misuse flags.
module clic_unwind
    import config_pkg::*;
#(
    parameter int Depth  = ClicStackDepth,
    parameter int PrioW  = ClicPrioWidth,
    parameter int PcW    = IMemAddrWidth,
    localparam int DepthW = $clog2(Depth + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [PcW-1:0]    push_pc,
    input  logic [PrioW-1:0]  push_prio,
    input  logic              pop,
    input  logic              err_clr,
    output logic [PcW-1:0]    tos_pc,
    output logic [PrioW-1:0]  tos_prio,
    output logic [DepthW-1:0] depth,
    output logic              empty,
    output logic              full,
    output logic              tail_chain,
    output logic              overflow,
    output logic              underflow
);

    localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    clic_frame_t       mem_q [Depth];
    logic [DepthW-1:0] depth_q, depth_d;
    logic              tail_q, tail_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              is_empty, is_full;
    logic              do_push, do_pop;
    logic [AddrW-1:0]  wr_idx, rd_idx;
    clic_frame_t       wr_frame;

    always_comb begin
        is_empty = (depth_q == '0);
        is_full  = (depth_q == DepthW'(Depth));

        // push+pop with a live frame is a tail-chain: the saved return context
        // stays put. With nothing saved, the pop has nothing to unwind.
        do_push = push && (pop ? is_empty : !is_full);
        do_pop  = pop && !push && !is_empty;

        depth_d = depth_q;
        if (do_push) begin
            depth_d = depth_q + 1'b1;
        end else if (do_pop) begin
            depth_d = depth_q - 1'b1;
        end

        tail_d = push && pop && !is_empty;
        // A fresh error event wins over a clear in the same cycle.
        ovf_d  = (push && !pop && is_full) || (ovf_q && !err_clr);
        udf_d  = (pop && !push && is_empty) || (udf_q && !err_clr);

        wr_idx        = AddrW'(depth_q);
        rd_idx        = AddrW'(depth_q - 1'b1);
        wr_frame.pc   = IMemAddrWidth'(push_pc);
        wr_frame.prio = ClicPrioWidth'(push_prio);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
            tail_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            tail_q  <= tail_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is never cleared; only the slot at the current depth is written.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem_q[wr_idx] <= wr_frame;
        end
    end

    always_comb begin
        tos_pc   = '0;
        tos_prio = '0;
        if (!is_empty) begin
            tos_pc   = PcW'(mem_q[rd_idx].pc);
            tos_prio = PrioW'(mem_q[rd_idx].prio);
        end
    end

    assign depth      = depth_q;
    assign empty      = is_empty;
    assign full       = is_full;
    assign tail_chain = tail_q;
    assign overflow   = ovf_q;
    assign underflow  = udf_q;

endmodule
